// File: rtl/tmr_scrub_pkg.sv
// Shared types and helpers for the TMR scrub controller.
// State encoding, default timing constants and an index-width helper.
package tmr_scrub_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        READ  = 3'd2,
        VOTE  = 3'd3,
        WRITE = 3'd4
    } scrub_state_e;

    localparam int DEF_INTERVAL   = 1024;
    localparam int DEF_RD_TIMEOUT = 15;

    // Bits needed to hold an index 0..n-1, never less than one.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tmr_word_voter.sv
// Bitwise 2-of-3 majority voter with disagreement flags.
// Purely combinational; shared by the TMR blocks.
module tmr_word_voter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] voted,
    output logic             mismatch,
    output logic             uncorr
);

    assign voted    = (a & b) | (b & c) | (a & c);
    assign mismatch = (a != voted) || (b != voted) || (c != voted);
    // All three copies differ pairwise: the vote cannot be trusted.
    assign uncorr   = (a != b) && (b != c) && (a != c);

endmodule

// File: rtl/tmr_scrub_ctrl.sv
// Round-robin scrubber for triplicated register banks: read, vote, write back.
// Optional per-bank sticky error map when TMR_SCRUB_STATS_EN is defined.
module tmr_scrub_ctrl
    import tmr_scrub_pkg::*;
#(
    parameter int N_BANKS    = 8,
    parameter int WIDTH      = 32,
    parameter int INTERVAL   = DEF_INTERVAL,
    parameter int RD_TIMEOUT = DEF_RD_TIMEOUT,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        en,
    input  logic                        force_scrub,
    input  logic                        clr_cnt,
    output logic [idx_w(N_BANKS)-1:0]   bank_sel,
    output logic                        rd_req,
    input  logic                        rd_valid,
    input  logic [WIDTH-1:0]            copy_a,
    input  logic [WIDTH-1:0]            copy_b,
    input  logic [WIDTH-1:0]            copy_c,
    output logic                        wr_en,
    output logic [WIDTH-1:0]            wr_data,
    output logic                        err_corr,
    output logic                        err_uncorr,
    output logic                        err_timeout,
    output logic [CNT_W-1:0]            err_cnt,
    output logic                        busy,
`ifdef TMR_SCRUB_STATS_EN
    output logic [N_BANKS-1:0]          err_map,
`endif
    output scrub_state_e                state_dbg
);

    localparam int BW = idx_w(N_BANKS);
    localparam int IW = idx_w(INTERVAL);
    localparam int TW = idx_w(RD_TIMEOUT);
    localparam logic [BW-1:0] BANK_LAST = BW'(N_BANKS - 1);
    localparam logic [IW-1:0] INT_LAST  = IW'(INTERVAL - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(RD_TIMEOUT - 1);

    scrub_state_e     state;
    logic [IW-1:0]    icnt;
    logic [TW-1:0]    tcnt;
    logic [WIDTH-1:0] cp_a, cp_b, cp_c;
    logic [WIDTH-1:0] voted;
    logic             mismatch, uncorr;
    logic [BW-1:0]    next_bank;

    assign state_dbg = state;
    assign next_bank = (bank_sel == BANK_LAST) ? '0 : bank_sel + BW'(1);

    tmr_word_voter #(.WIDTH(WIDTH)) u_voter (
        .a        (cp_a),
        .b        (cp_b),
        .c        (cp_c),
        .voted    (voted),
        .mismatch (mismatch),
        .uncorr   (uncorr)
    );

    // Read handshake: rd_req rises on entry to READ and holds until the cycle
    // rd_valid is sampled high (or the timeout fires); rd_valid is ignored
    // whenever rd_req is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            bank_sel    <= '0;
            icnt        <= '0;
            tcnt        <= '0;
            cp_a        <= '0;
            cp_b        <= '0;
            cp_c        <= '0;
            rd_req      <= 1'b0;
            wr_en       <= 1'b0;
            wr_data     <= '0;
            err_corr    <= 1'b0;
            err_uncorr  <= 1'b0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            wr_en       <= 1'b0;
            err_corr    <= 1'b0;
            err_uncorr  <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= WAIT;
                        icnt  <= '0;
                    end
                end
                WAIT: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (icnt == INT_LAST || force_scrub) begin
                        state  <= READ;
                        rd_req <= 1'b1;
                        busy   <= 1'b1;
                        tcnt   <= '0;
                    end else begin
                        icnt <= icnt + IW'(1);
                    end
                end
                READ: begin
                    if (rd_valid) begin
                        cp_a   <= copy_a;
                        cp_b   <= copy_b;
                        cp_c   <= copy_c;
                        rd_req <= 1'b0;
                        state  <= VOTE;
                    end else if (tcnt == TO_LAST) begin
                        rd_req      <= 1'b0;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                        bank_sel    <= next_bank;
                        icnt        <= '0;
                        state       <= en ? WAIT : IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                VOTE: begin
                    if (mismatch) begin
                        state      <= WRITE;
                        wr_en      <= 1'b1;
                        wr_data    <= voted;
                        err_uncorr <= uncorr;
                        err_corr   <= !uncorr;
                    end else begin
                        busy     <= 1'b0;
                        bank_sel <= next_bank;
                        icnt     <= '0;
                        state    <= en ? WAIT : IDLE;
                    end
                end
                WRITE: begin
                    busy     <= 1'b0;
                    bank_sel <= next_bank;
                    icnt     <= '0;
                    state    <= en ? WAIT : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The count updates at the end of WRITE so a clear seen alongside the
    // error pulse still wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt <= '0;
        end else if (clr_cnt) begin
            err_cnt <= '0;
        end else if (state == WRITE && !(&err_cnt)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

`ifdef TMR_SCRUB_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_map <= '0;
        end else if (clr_cnt) begin
            err_map <= '0;
        end else if (state == WRITE) begin
            err_map[bank_sel] <= 1'b1;
        end
    end
`endif

endmodule
